record_fifo: RTL and testbench

Synchronous word-to-record FIFO with a valid/ready handshake on both sides and a registered output stage. It accepts one WordSize word per cycle and assembles RecordWords consecutive words into one record. It sits between the byte-stream receiver and the motion-command decoder. It adds reset, flush, selectable word order, an almost-full threshold, a level report and a sticky overflow flag.

---
 rtl/record_fifo_if.sv | 22 ++
 rtl/record_fifo.sv | 97 +++++++++
 tb/tb_record_fifo.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/record_fifo_if.sv
// rtl/record_fifo_if.sv - word-in / record-out handshake bundle for record_fifo
interface record_fifo_if #(
    parameter int WordSize    = 8,
    parameter int RecordWords = 16
);
    logic                            in_valid;
    logic                            in_ready;
    logic [WordSize-1:0]             data_in;
    logic                            out_valid;
    logic                            out_ready;
    logic [WordSize*RecordWords-1:0] out_data;

    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/record_fifo.sv
// rtl/record_fifo.sv - word-to-record FIFO with registered record output stage
module record_fifo #(
    parameter int WordSize        = 8,
    parameter int RecordWords     = 16,
    parameter int Depth           = 8,
    parameter int MsbFirst        = 0,
    parameter int AlmostFullWords = 16,
    localparam int StorageSize    = Depth * RecordWords,
    localparam int PosW           = $clog2(StorageSize),
    localparam int LvlW           = $clog2(StorageSize + RecordWords) + 1
) (
    input  logic            clk,
    input  logic            reset,
    record_fifo_if.slave    s,
    input  logic            flush,
    output logic            almost_full,
    output logic [LvlW-1:0] level,
    output logic            overflow,
    input  logic            clear_overflow
);
    logic [WordSize-1:0]             mem [StorageSize];
    logic [PosW:0]                   wr_ptr;
    logic [PosW:0]                   rd_ptr;
    logic [PosW:0]                   stored;
    logic [PosW:0]                   free_words;
    logic                            out_valid_q;
    logic [WordSize*RecordWords-1:0] out_data_q;
    logic [WordSize*RecordWords-1:0] rec;
    logic [PosW-1:0]                 rd_idx;
    logic                            wr_en;
    logic                            load;

    assign stored     = wr_ptr - rd_ptr;
    assign free_words = (PosW+1)'(StorageSize) - stored;
    assign rd_idx     = rd_ptr[PosW-1:0];

    assign s.in_ready = !reset && !flush && (stored < (PosW+1)'(StorageSize));
    assign wr_en      = s.in_valid && s.in_ready;
    assign load       = !reset && !flush && (stored >= (PosW+1)'(RecordWords))
                        && (!out_valid_q || s.out_ready);

    assign s.out_valid  = out_valid_q && !reset;
    assign s.out_data   = out_data_q;
    assign level        = reset ? '0
                        : LvlW'(stored) + (out_valid_q ? LvlW'(RecordWords) : '0);
    assign almost_full  = reset ? (StorageSize <= AlmostFullWords)
                        : (free_words <= (PosW+1)'(AlmostFullWords));

    // rd_ptr only moves in whole records, so a record never straddles the wrap point
    always_comb begin
        rec = '0;
        for (int i = 0; i < RecordWords; i++) begin
            if (MsbFirst != 0)
                rec[(RecordWords-1-i)*WordSize +: WordSize] = mem[rd_idx + PosW'(i)];
            else
                rec[i*WordSize +: WordSize] = mem[rd_idx + PosW'(i)];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[PosW-1:0]] <= s.data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (load) begin
                rd_ptr      <= rd_ptr + (PosW+1)'(RecordWords);
                out_data_q  <= rec;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && s.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // A rejected word sets the flag even if clear_overflow is asserted alongside
    always_ff @(posedge clk) begin
        if (reset)
            overflow <= 1'b0;
        else if (s.in_valid && !s.in_ready && !flush)
            overflow <= 1'b1;
        else if (clear_overflow)
            overflow <= 1'b0;
    end
endmodule

// File: tb/tb_record_fifo.sv
// tb/tb_record_fifo.sv - self-checking bench for record_fifo
module tb_record_fifo;
    localparam int W  = 8;
    localparam int RW = 4;
    localparam int DP = 2;
    localparam int AF = 2;
    localparam int SS = DP * RW;
    localparam int LW = $clog2(SS + RW) + 1;

    logic clk = 1'b0;
    logic reset, flush, clear_overflow;
    logic af0, af1, ovf0, ovf1;
    logic [LW-1:0] lvl0, lvl1;

    record_fifo_if #(.WordSize(W), .RecordWords(RW)) ifc ();
    record_fifo_if #(.WordSize(W), .RecordWords(RW)) ifc1 ();

    assign ifc1.in_valid  = ifc.in_valid;
    assign ifc1.data_in   = ifc.data_in;
    assign ifc1.out_ready = ifc.out_ready;

    record_fifo #(.WordSize(W), .RecordWords(RW), .Depth(DP), .MsbFirst(0), .AlmostFullWords(AF)) u0 (
        .clk(clk), .reset(reset), .s(ifc), .flush(flush), .almost_full(af0),
        .level(lvl0), .overflow(ovf0), .clear_overflow(clear_overflow));

    record_fifo #(.WordSize(W), .RecordWords(RW), .Depth(DP), .MsbFirst(1), .AlmostFullWords(AF)) u1 (
        .clk(clk), .reset(reset), .s(ifc1), .flush(flush), .almost_full(af1),
        .level(lvl1), .overflow(ovf1), .clear_overflow(clear_overflow));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a plain word queue plus one output slot
    logic [W-1:0]  mq[$];
    bit            mv = 0;
    bit            movf = 0;
    bit            started = 0;
    logic [31:0]   md, md_msb;
    logic [31:0]   cap[$];

    always @(posedge clk) begin : model
        int st;
        bit rdy, ld;
        st  = mq.size();
        rdy = !reset && !flush && st < SS;
        ld  = !reset && !flush && st >= RW && (!mv || ifc.out_ready);
        if (reset) movf = 0;
        else if (ifc.in_valid && !rdy && !flush) movf = 1;
        else if (clear_overflow) movf = 0;
        if (reset) begin
            mq.delete(); mv = 0; started = 1;
        end else if (flush) begin
            mq.delete(); mv = 0;
        end else begin
            if (ld) begin
                md = 0; md_msb = 0;
                for (int i = 0; i < RW; i++) begin
                    logic [31:0] w;
                    w = 32'(mq.pop_front());
                    md     = md     | (w << (8 * i));
                    md_msb = md_msb | (w << (8 * (RW - 1 - i)));
                end
                mv = 1;
            end else if (mv && ifc.out_ready) begin
                mv = 0;
            end
            if (ifc.in_valid && rdy) mq.push_back(ifc.data_in);
        end
    end

    always @(negedge clk) begin : compare
        if (started) begin
            int st;
            st = mq.size();
            check("in_ready",    ifc.in_ready,  64'(!reset && !flush && st < SS));
            check("out_valid",   ifc.out_valid, 64'(!reset && mv));
            check("out_valid_m", ifc1.out_valid, 64'(!reset && mv));
            check("level",       64'(lvl0),     reset ? 64'd0 : 64'(st + (mv ? RW : 0)));
            check("almost_full", af0,           reset ? 64'(SS <= AF) : 64'((SS - st) <= AF));
            check("overflow",    ovf0,          64'(movf));
            if (!reset && mv) begin
                check("out_data",     ifc.out_data,  md);
                check("out_data_msb", ifc1.out_data, md_msb);
                if (ifc.out_ready) cap.push_back(ifc.out_data);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] w);
        ifc.in_valid = 1'b1;
        ifc.data_in  = w;
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; clear_overflow = 1'b0;
        ifc.in_valid = 1'b0; ifc.data_in = '0; ifc.out_ready = 1'b0;
        idle(1);
        check("rst_in_ready", ifc.in_ready, 0);
        check("rst_level", 64'(lvl0), 0);
        check("rst_almost_full", af0, 0);
        idle(1);
        reset = 1'b0;

        // basic record assembly, both word orders
        for (int i = 1; i <= 4; i++) push(8'(i));
        check("basic_latency", ifc.out_valid, 0);
        idle(1);
        check("basic_valid", ifc.out_valid, 1);
        check("basic_lsb", ifc.out_data, 32'h04030201);
        check("basic_msb", ifc1.out_data, 32'h01020304);
        check("basic_level", 64'(lvl0), 4);
        ifc.out_ready = 1'b1; idle(1); ifc.out_ready = 1'b0;
        check("basic_drained", 64'(lvl0), 0);

        // fill, back-pressure and overflow
        for (int i = 0; i < 12; i++) push(8'(8'h11 + i));
        check("fill_in_ready", ifc.in_ready, 0);
        check("fill_level", 64'(lvl0), 12);
        check("fill_almost_full", af0, 1);
        push(8'hEE);
        check("ovf_set", ovf0, 1);
        clear_overflow = 1'b1; idle(1); clear_overflow = 1'b0;
        check("ovf_cleared", ovf0, 0);
        ifc.out_ready = 1'b1; idle(4); ifc.out_ready = 1'b0;
        check("fill_drained", 64'(lvl0), 0);

        // streaming with wrap-around from a fresh start
        reset = 1'b1; idle(1); reset = 1'b0;
        cap.delete();
        ifc.out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) push(8'(i));
        idle(3);
        ifc.out_ready = 1'b0;
        check("stream_count", 64'(cap.size()), 4);
        if (cap.size() == 4) begin
            check("stream_rec1", cap[1], 32'h08070605);
            check("stream_rec3", cap[3], 32'h100F0E0D);
        end

        // simultaneous load and pop
        for (int i = 0; i < 8; i++) push(8'(8'h21 + i));
        idle(1);
        ifc.out_ready = 1'b1;
        check("lp_rec1", ifc.out_data, 32'h24232221);
        idle(1);
        check("lp_valid2", ifc.out_valid, 1);
        check("lp_rec2", ifc.out_data, 32'h28272625);
        idle(1);
        check("lp_valid_fall", ifc.out_valid, 0);
        check("lp_level", 64'(lvl0), 0);
        ifc.out_ready = 1'b0;

        // partial record and flush
        for (int i = 0; i < 6; i++) push(8'(8'h31 + i));
        check("part_level", 64'(lvl0), 6);
        flush = 1'b1; ifc.in_valid = 1'b1; ifc.data_in = 8'hEE;
        #1;
        check("flush_in_ready", ifc.in_ready, 0);
        idle(1);
        flush = 1'b0; ifc.in_valid = 1'b0;
        check("flush_level", 64'(lvl0), 0);
        check("flush_out_valid", ifc.out_valid, 0);
        check("flush_ovf", ovf0, 0);
        for (int i = 0; i < 4; i++) push(8'(8'h41 + i));
        idle(1);
        check("flush_rec", ifc.out_data, 32'h44434241);
        ifc.out_ready = 1'b1; idle(1); ifc.out_ready = 1'b0;

        // reset in the middle of a record
        for (int i = 0; i < 3; i++) push(8'(8'h51 + i));
        reset = 1'b1; ifc.in_valid = 1'b1; ifc.data_in = 8'h54;
        #1;
        check("mid_rst_in_ready", ifc.in_ready, 0);
        idle(1);
        reset = 1'b0; ifc.in_valid = 1'b0;
        check("mid_rst_level", 64'(lvl0), 0);
        check("mid_rst_ovf", ovf0, 0);
        for (int i = 0; i < 4; i++) push(8'(8'h61 + i));
        idle(1);
        check("mid_rst_rec", ifc.out_data, 32'h64636261);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
